// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demultiplexer: one valid/ready producer steered by
// in_sel to one of two independently drained FIFOs (in_sel=1 -> A, 0 -> B).

module stream_demux2_fifo #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [N-1:0]             push_data,
    input  logic                     pop_ready,
    output logic [N-1:0]             head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic do_push;
    logic do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

    // Push is also gated on !full locally so the count can never overflow.
    assign do_push = push && !full && !flush;
    assign do_pop  = head_valid && pop_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

module stream_demux2 #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [N-1:0]             in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N-1:0]             a_data,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [N-1:0]             b_data,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic [$clog2(DEPTH):0]   b_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic accept;
    logic push_a;
    logic push_b;

    // Readiness looks only at the selected side's occupancy; a pop on a full
    // FIFO in the same cycle deliberately does not reopen it.
    assign in_ready = !flush && (in_sel ? (a_count != CW'(DEPTH))
                                        : (b_count != CW'(DEPTH)));
    assign accept   = in_valid && in_ready;
    assign push_a   = accept && in_sel;
    assign push_b   = accept && !in_sel;

    stream_demux2_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push_a),
        .push_data  (in_data),
        .pop_ready  (a_ready),
        .head_data  (a_data),
        .head_valid (a_valid),
        .count      (a_count)
    );

    stream_demux2_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push_b),
        .push_data  (in_data),
        .pop_ready  (b_ready),
        .head_data  (b_data),
        .head_valid (b_valid),
        .count      (b_count)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// Scoreboard bench for stream_demux2: the driver queues expected payloads on
// accept, and a negedge monitor checks occupancy and pops on every handshake.

module tb_stream_demux2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  a_count;
    logic [1:0]  b_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    stream_demux2 #(
        .N     (32),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: occupancy must match the model; every handshake pops the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_valid", {31'b0, a_valid}, {31'b0, exp_a.size() != 0});
            chk("b_valid", {31'b0, b_valid}, {31'b0, exp_b.size() != 0});
            chk("a_count", {30'b0, a_count}, 32'(exp_a.size()));
            chk("b_count", {30'b0, b_count}, 32'(exp_b.size()));
            if (!flush && a_valid && a_ready) begin
                if (exp_a.size() == 0) chk("a_unexpected", 32'd1, 32'd0);
                else chk("a_data", a_data, exp_a.pop_front());
            end
            if (!flush && b_valid && b_ready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
                else chk("b_data", b_data, exp_b.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [31:0] d);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("push_timeout", 32'd0, 32'd1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            if (sel) exp_a.push_back(d);
            else     exp_b.push_back(d);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 50) begin
            n++;
            step();
        end
        if (exp_a.size() != 0 || exp_b.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
        a_ready = 1'b0;
        b_ready = 1'b0;
    endtask

    task automatic check_ready_both();
        in_sel = 1'b1;
        #1 chk("in_ready_sel1", {31'b0, in_ready}, 32'd1);
        in_sel = 1'b0;
        #1 chk("in_ready_sel0", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_ready_both();

        // Route and latency
        step();
        push(1'b1, 32'hDEADBEEF);
        push(1'b0, 32'h12345678);
        @(negedge clk);
        chk("route_a_data", a_data, 32'hDEADBEEF);
        chk("route_b_data", b_data, 32'h12345678);
        chk("route_a_count", {30'b0, a_count}, 32'd1);
        chk("route_b_count", {30'b0, b_count}, 32'd1);
        step();
        drain();

        // Full backpressure on A; B remains open
        push(1'b1, 32'h1);
        push(1'b1, 32'h2);
        @(negedge clk);
        in_sel = 1'b1;
        #1 chk("full_in_ready_a", {31'b0, in_ready}, 32'd0);
        chk("full_a_count", {30'b0, a_count}, 32'd2);
        in_sel = 1'b0;
        #1 chk("full_in_ready_b", {31'b0, in_ready}, 32'd1);
        step();
        in_sel  = 1'b1;
        a_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_ready", {31'b0, in_ready}, 32'd0);
        step();
        a_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_ready", {31'b0, in_ready}, 32'd1);
        chk("after_pop_a_data", a_data, 32'h2);
        step();
        drain();

        // Streaming with pointer wrap
        a_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(1'b1, 32'(i));
        drain();

        // Flush collides with a push and a pop
        push(1'b1, 32'hA1);
        push(1'b1, 32'hA2);
        push(1'b0, 32'hB1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hBAD;
        a_ready  = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        exp_a.delete();
        exp_b.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        @(negedge clk);
        chk("flush_a_count", {30'b0, a_count}, 32'd0);
        chk("flush_b_count", {30'b0, b_count}, 32'd0);
        chk("flush_a_valid", {31'b0, a_valid}, 32'd0);
        chk("flush_b_valid", {31'b0, b_valid}, 32'd0);
        step();

        // Independence: B full and stalled, A streams
        push(1'b0, 32'hB0);
        push(1'b0, 32'hB5);
        a_ready = 1'b1;
        push(1'b1, 32'hC0);
        push(1'b1, 32'hC1);
        push(1'b1, 32'hC2);
        push(1'b1, 32'hC3);
        step();
        step();
        @(negedge clk);
        chk("indep_a_empty", {30'b0, a_count}, 32'd0);
        chk("indep_b_count", {30'b0, b_count}, 32'd2);
        chk("indep_b_data", b_data, 32'hB0);
        step();
        drain();

        // Asynchronous reset mid-stream
        push(1'b1, 32'h55);
        push(1'b1, 32'h66);
        rst_n = 1'b0;
        exp_a.delete();
        exp_b.delete();
        #1;
        chk("mid_rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("mid_rst_a_count", {30'b0, a_count}, 32'd0);
        chk("mid_rst_b_count", {30'b0, b_count}, 32'd0);
        chk("mid_rst_a_data", a_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_ready_both();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- Registered 1-to-2 stream demultiplexer with valid/ready handshakes.
- Steers one producer stream to one of two consumer streams, each behind its own small FIFO.
- Used where one pipeline result must reach one of two downstream units, e.g. the M-extension divider and the ALU writeback path, without stalling the unselected path.
- Select sense matches the core's 2:1 select convention: in_sel=1 routes to port A, in_sel=0 routes to port B.

Parameters:
- N, 32, data width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both FIFOs.
- in_data  input  N  input payload.
- in_sel  input  1  route select: 1 = A, 0 = B.
- in_valid  input  1  input payload valid.
- in_ready  output  1  block accepts the input this cycle.
- a_data  output  N  head entry of FIFO A.
- a_valid  output  1  FIFO A not empty.
- a_ready  input  1  consumer A takes the head entry.
- b_data  output  N  head entry of FIFO B.
- b_valid  output  1  FIFO B not empty.
- b_ready  input  1  consumer B takes the head entry.
- a_count  output  $clog2(DEPTH)+1  FIFO A occupancy.
- b_count  output  $clog2(DEPTH)+1  FIFO B occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and counts clear to 0; a_valid=b_valid=0; a_data=b_data=0 (storage cleared).
  - Release is synchronous to clk; the first accept is possible on the first rising edge after release.
- in_ready (combinational):
  - in_ready = !flush && (in_sel ? a_count!=DEPTH : b_count!=DEPTH).
  - Depends on in_sel; it does not depend on in_valid.
- Accept rule:
  - A transfer occurs on an edge where in_valid && in_ready.
  - The payload is written to the tail of the selected FIFO; the other FIFO is untouched.
- Producer contract: once in_valid is high, in_data and in_sel stay stable until accepted. The block does not check this.
- Output side:
  - x_valid = (x_count != 0); x_data = FIFO head.
  - A pop occurs on an edge where x_valid && x_ready.
  - x_ready while x_valid=0 has no effect.
- Latency:
  - Accepted data appears on x_data/x_valid on the cycle after the accepting edge.
  - There is no combinational in→out bypass.
- Full FIFO: in_ready=0 whenever the selected FIFO is full, even if that FIFO pops the same cycle. This is a deliberate choice; there is no same-cycle pass-through.
- Push and pop on the same FIFO in the same cycle (not full, not empty): count unchanged, head advances, tail advances.
- Empty FIFO with push: the entry becomes valid next cycle. A same-cycle pop is impossible because x_valid=0.
- Independence: A and B pop independently. A stalled consumer on one side never blocks traffic routed to the other side.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register disambiguates full from empty.
- Count updates per FIFO: +1 on push only, -1 on pop only, unchanged on both or neither. The count never exceeds DEPTH and never goes below 0.
- Flush:
  - Next edge: both counts and pointers go to 0 and both x_valid go low.
  - in_ready is forced 0 during flush, so no push occurs.
  - Pops in the flush cycle are discarded; flush wins.
  - Storage contents need not clear.
- Ordering: FIFO order per output. Relative order between A and B is not preserved or tracked.

Test Plan:
- Reset then idle: rst_n=0 mid-stream with A holding 2 entries -> immediately a_valid=b_valid=0 and a_count=b_count=0. After release, in_ready=1 for both in_sel values.
- Route and latency:
  - Push 0xDEADBEEF with in_sel=1, then 0x12345678 with in_sel=0, holding a_ready=b_ready=0.
  - Required: a_valid rises the cycle after the first accept with a_data=0xDEADBEEF; b_data=0x12345678 one cycle later; both counts=1.
- Full backpressure:
  - a_ready=0, push 0x1, 0x2 to A -> a_count=2, in_ready=0 with in_sel=1 and in_ready=1 with in_sel=0.
  - Then assert a_ready for one cycle -> 0x1 popped, in_ready with in_sel=1 returns high the next cycle.
- Streaming wrap: a_ready=1 and continuous push of 0..9 to A -> a_data sequence 0..9 in order, a_count stays ≤1, no gaps after the first output.
- Flush collision:
  - A holds 2 entries and B holds 1; assert flush together with in_valid=1 and a_ready=1.
  - Required next cycle: all counts 0, both valid low, no accept (in_ready=0 during flush).
- Independence: b_ready=0 with B full; push 4 values to A with a_ready=1 -> all 4 delivered on A, and b_count stays 2 with B contents unchanged.
